// File: rtl/prog_counter_if.sv
// Control and status bundle for the programmable counter.
// The master drives run control, arithmetic setup and the event input;
// the slave (the counter) returns the count, LED window and status flags.
interface prog_counter_if #(
  parameter int WIDTH   = 24,
  parameter int LED_W   = 10,
  parameter int PRESC_W = 16,
  parameter int TAP_W   = 5
);
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic               up_dn;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   modulo;
  logic [PRESC_W-1:0] prescale;
  logic               evt_in;
  logic [TAP_W-1:0]   tap_sel;
  logic [WIDTH-1:0]   count_out;
  logic [LED_W-1:0]   led_out;
  logic               tc_pulse;
  logic               done;
  logic               running;

  modport master (
    output start, stop, mode, up_dn, load, load_val, modulo, prescale, evt_in, tap_sel,
    input  count_out, led_out, tc_pulse, done, running
  );

  modport slave (
    input  start, stop, mode, up_dn, load, load_val, modulo, prescale, evt_in, tap_sel,
    output count_out, led_out, tc_pulse, done, running
  );
endinterface

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler or synchronised event stepping,
// modulo wrap, one-shot completion, load, terminal-count pulse and LED tap.
module prog_counter #(
  parameter int WIDTH   = 24,
  parameter int LED_W   = 10,
  parameter int PRESC_W = 16,
  parameter int TAP_W   = 5
) (
  input  logic          clk,
  input  logic          reset,
  prog_counter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  localparam logic [1:0]       M_FREE  = 2'd0;
  localparam logic [1:0]       M_ONE   = 2'd1;
  localparam logic [1:0]       M_EVT   = 2'd2;
  localparam logic [1:0]       M_HOLD  = 2'd3;
  localparam logic [TAP_W-1:0] MAX_TAP = TAP_W'(WIDTH - LED_W);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               evt_s1_q, evt_s2_q, evt_d_q;
  logic               tc_q, tc_d;
  logic [LED_W-1:0]   led_q, led_d;

  logic               presc_act, tick, evt_rise, step;
  logic               terminal, arrive;
  logic [WIDTH-1:0]   step_val, shifted;
  logic [TAP_W-1:0]   tap_eff;

  // Step source: prescaler tick in modes 0/1, synchronised event edge in mode 2; load wins.
  always_comb begin
    presc_act = (state_q == S_RUN) && ((bus.mode == M_FREE) || (bus.mode == M_ONE));
    tick      = presc_act && (presc_q == bus.prescale);
    evt_rise  = evt_s2_q & ~evt_d_q;
    step      = 1'b0;
    if (!bus.load && (state_q == S_RUN)) begin
      if (bus.mode == M_EVT)       step = evt_rise;
      else if (bus.mode != M_HOLD) step = tick;
    end
  end

  // Step arithmetic; arrive marks reaching the end of the range, which ends a one-shot run.
  always_comb begin
    if (bus.up_dn) begin
      terminal = (count_q >= bus.modulo);
      step_val = terminal ? '0 : count_q + WIDTH'(1);
      arrive   = (step_val == bus.modulo);
    end else begin
      terminal = (count_q == '0);
      step_val = terminal ? bus.modulo : count_q - WIDTH'(1);
      arrive   = (step_val == '0);
    end
  end

  // FSM next state: stop beats start; a one-shot run parks in DONE at the terminal value.
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.start) state_d = S_RUN;
        S_RUN:   if (step && (bus.mode == M_ONE) && arrive) state_d = S_DONE;
        S_DONE:  if (bus.start) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    bus.running = (state_q == S_RUN);
    bus.done    = (state_q == S_DONE);
  end

  // Next count, prescaler, terminal pulse and clamped LED window.
  always_comb begin
    count_d = count_q;
    if (bus.load)                                        count_d = bus.load_val;
    else if ((state_q == S_DONE) && bus.start && !bus.stop) count_d = bus.up_dn ? '0 : bus.modulo;
    else if (step)                                       count_d = step_val;

    tc_d = step & terminal;

    presc_d = presc_q;
    if (bus.load || ((state_d == S_RUN) && (state_q != S_RUN))) presc_d = '0;
    else if (presc_act) presc_d = tick ? '0 : presc_q + PRESC_W'(1);

    tap_eff = (bus.tap_sel > MAX_TAP) ? MAX_TAP : bus.tap_sel;
    shifted = count_q >> tap_eff;
    led_d   = shifted[LED_W-1:0];
  end

  // State, datapath and event synchroniser registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      presc_q  <= '0;
      evt_s1_q <= 1'b0;
      evt_s2_q <= 1'b0;
      evt_d_q  <= 1'b0;
      tc_q     <= 1'b0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      evt_s1_q <= bus.evt_in;
      evt_s2_q <= evt_s1_q;
      evt_d_q  <= evt_s2_q;
      tc_q     <= tc_d;
      led_q    <= led_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.led_out   = led_q;
  assign bus.tc_pulse  = tc_q;

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: directed scenarios with fixed expectations plus a
// randomized phase, all tracked cycle by cycle against a behavioural model.
module tb_prog_counter;
  localparam int WIDTH   = 24;
  localparam int LED_W   = 10;
  localparam int PRESC_W = 16;
  localparam int TAP_W   = 5;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  prog_counter_if #(.WIDTH(WIDTH), .LED_W(LED_W), .PRESC_W(PRESC_W), .TAP_W(TAP_W)) bus ();

  prog_counter #(.WIDTH(WIDTH), .LED_W(LED_W), .PRESC_W(PRESC_W), .TAP_W(TAP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: run state 0 idle / 1 run / 2 done, count, cycles-since-tick,
  // and the last three sampled evt_in values.
  int               m_st = 0;
  logic [WIDTH-1:0] m_cnt = '0;
  logic [PRESC_W-1:0] m_presc = '0;
  logic             m_tc = 1'b0;
  logic [LED_W-1:0] m_led = '0;
  logic [2:0]       m_evh = '0;

  task automatic model_edge();
    logic rise, active, tick_m, stp, wrap, hit;
    logic [WIDTH-1:0] nxt;
    int ns, tap;
    if (!reset) begin
      m_st = 0; m_cnt = '0; m_presc = '0; m_tc = 1'b0; m_led = '0; m_evh = '0;
      return;
    end
    tap    = (int'(bus.tap_sel) > WIDTH - LED_W) ? WIDTH - LED_W : int'(bus.tap_sel);
    m_led  = LED_W'(m_cnt >> tap);
    rise   = m_evh[1] && !m_evh[2];
    active = (m_st == 1) && (bus.mode < 2);
    tick_m = active && (m_presc == bus.prescale);
    stp    = !bus.load && (m_st == 1) &&
             (((bus.mode < 2) && tick_m) || ((bus.mode == 2) && rise));
    if (bus.up_dn) begin
      wrap = (m_cnt >= bus.modulo);
      nxt  = wrap ? '0 : m_cnt + 1;
      hit  = (nxt == bus.modulo);
    end else begin
      wrap = (m_cnt == 0);
      nxt  = wrap ? bus.modulo : m_cnt - 1;
      hit  = (nxt == 0);
    end
    ns = m_st;
    if (bus.stop) ns = 0;
    else if (bus.start && m_st != 1) ns = 1;
    else if (stp && bus.mode == 1 && hit) ns = 2;
    if (bus.load || (ns == 1 && m_st != 1)) m_presc = '0;
    else if (active) m_presc = tick_m ? '0 : m_presc + 1;
    if (bus.load) m_cnt = bus.load_val;
    else if (m_st == 2 && bus.start && !bus.stop) m_cnt = bus.up_dn ? '0 : bus.modulo;
    else if (stp) m_cnt = nxt;
    m_tc  = stp && wrap;
    m_evh = {m_evh[1:0], bus.evt_in};
    m_st  = ns;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_count", bus.count_out, m_cnt);
    check("model_led", bus.led_out, m_led);
    check("model_flags", {bus.tc_pulse, bus.done, bus.running}, {m_tc, m_st == 2, m_st == 1});
  endtask

  task automatic do_reset();
    reset = 1'b0; cycle(); cycle(); reset = 1'b1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; cycle(); bus.stop = 1'b0;
  endtask

  task automatic evt_pulse();
    bus.evt_in = 1'b1; repeat (3) cycle();
    bus.evt_in = 1'b0; repeat (3) cycle();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int evt_left;
    int guard;
    reset = 1'b0;
    bus.start = 0; bus.stop = 0; bus.mode = 0; bus.up_dn = 1; bus.load = 0;
    bus.load_val = '0; bus.modulo = 24'd5; bus.prescale = '0; bus.evt_in = 0; bus.tap_sel = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_count", bus.count_out, 0);
    check("rst_led", bus.led_out, 0);
    check("rst_flags", {bus.tc_pulse, bus.done, bus.running}, 3'b000);

    // Free-run up, modulo 5, tick every cycle
    pulse_start();
    check("m0_running", bus.running, 1);
    for (int i = 1; i <= 7; i++) begin
      cycle();
      check("m0_seq", bus.count_out, i % 6);
      check("m0_tc", bus.tc_pulse, (i == 6));
    end
    pulse_stop();
    check("m0_stopped", bus.running, 0);

    // One-shot down, modulo 3, tick every 3 cycles, from reset
    do_reset();
    bus.mode = 2'd1; bus.up_dn = 0; bus.modulo = 24'd3; bus.prescale = 16'd2;
    pulse_start();
    repeat (3) cycle();
    check("os_wrap", bus.count_out, 3);
    check("os_wrap_tc", bus.tc_pulse, 1);
    repeat (9) cycle();
    check("os_done", bus.done, 1);
    check("os_hold", bus.count_out, 0);
    repeat (6) cycle();
    check("os_still", {bus.count_out, bus.tc_pulse}, 25'd0);
    pulse_start();
    check("os_preset", bus.count_out, 3);
    check("os_rerun", bus.running, 1);
    repeat (9) cycle();
    check("os_done2", {bus.done, bus.count_out}, 25'h1000000);

    // Event counting, full-width modulo, latency and freeze on stop
    pulse_stop();
    bus.mode = 2'd2; bus.up_dn = 1; bus.modulo = '1;
    bus.load = 1; bus.load_val = '0; cycle(); bus.load = 0;
    pulse_start();
    bus.evt_in = 1; cycle(); cycle();
    check("evt_lat2", bus.count_out, 0);
    cycle();
    check("evt_lat3", bus.count_out, 1);
    bus.evt_in = 0; repeat (3) cycle();
    repeat (3) evt_pulse();
    check("evt_four", bus.count_out, 4);
    evt_pulse();
    pulse_stop();
    repeat (2) evt_pulse();
    check("evt_frozen", bus.count_out, 5);

    // Load coincident with a tick, then terminal step from above modulo
    bus.mode = 2'd0; bus.up_dn = 1; bus.modulo = 24'd50; bus.prescale = '0;
    pulse_start();
    repeat (2) cycle();
    bus.load = 1; bus.load_val = 24'd100; cycle(); bus.load = 0;
    check("ld_val", bus.count_out, 100);
    cycle();
    check("ld_wrap", bus.count_out, 0);
    check("ld_tc", bus.tc_pulse, 1);

    // Clamped LED tap
    pulse_stop();
    bus.tap_sel = 5'd31;
    bus.load = 1; bus.load_val = 24'hABCDEF; cycle(); bus.load = 0;
    check("tap_cnt", bus.count_out, 24'hABCDEF);
    cycle();
    check("tap_led", bus.led_out, 10'h2AF);

    // Reset mid-run with start held
    bus.tap_sel = '0;
    bus.load = 1; bus.load_val = '0; cycle(); bus.load = 0;
    pulse_start();
    guard = 0;
    while (bus.count_out != 7 && guard < 40) begin cycle(); guard++; end
    check("mr_reach7", bus.count_out, 7);
    reset = 0; bus.start = 1; cycle();
    check("mr_count", bus.count_out, 0);
    check("mr_flags", {bus.tc_pulse, bus.done, bus.running}, 3'b000);
    bus.start = 0; reset = 1;
    repeat (5) cycle();
    check("mr_idle", {bus.running, bus.count_out}, 25'd0);

    // Randomized phase
    evt_left = 2;
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 499) != 0);
      bus.start = ($urandom_range(0, 15) == 0);
      bus.stop  = ($urandom_range(0, 59) == 0);
      bus.load  = ($urandom_range(0, 49) == 0);
      bus.load_val = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 60));
      if ($urandom_range(0, 79) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bus.up_dn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0)
        bus.modulo = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom_range(0, 20));
      if (bus.stop && $urandom_range(0, 1) == 0) bus.prescale = PRESC_W'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) bus.tap_sel = TAP_W'($urandom_range(0, 31));
      evt_left--;
      if (evt_left <= 0) begin
        bus.evt_in = ~bus.evt_in;
        evt_left = $urandom_range(2, 5);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
